// File: rtl/proc_feeder.sv
// Instruction sequencer driving the 9-bit processor DIN/Run/Done handshake from a loadable program memory.
// Optional single-step mode (PAUSE state, Step input) is enabled by defining PROC_FEEDER_STEP_EN.
module proc_feeder #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
`ifdef PROC_FEEDER_STEP_EN
    input  logic          Step,
`endif
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [8:0]    LoadData,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [7:0]    InstrCount
);

    // state | meaning
    // IDLE  | waiting for first Start after reset
    // ISSUE | read mem[PC], pulse Run with the instruction word
    // IMM   | present the mvi immediate on DIN
    // WAIT  | wait for Done, timeout counter running
    // HALT  | halt opcode reached or PC wrapped
    // ERR   | Done timeout
    // PAUSE | (step mode) hold until Step
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_IMM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
`ifdef PROC_FEEDER_STEP_EN
    localparam logic [2:0] S_PAUSE = 3'd6;
`endif

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam int         TW      = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic [8:0]    mem [DEPTH];
    logic [8:0]    word;
    logic [TW-1:0] tmo_cnt;
    logic          wrapped;
    logic          pc_last;
    logic          busy;

    assign word    = mem[PC];
    assign pc_last = (PC == AW'(DEPTH - 1));

`ifdef PROC_FEEDER_STEP_EN
    assign busy = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT) || (state == S_PAUSE);
`else
    assign busy = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
`endif
    assign Busy = busy;

    // Write lands on the same edge that accepts Start, so the first ISSUE sees it.
    always_ff @(posedge Clock) begin
        if (LoadEn && !busy) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            DIN        <= '0;
            Run        <= 1'b0;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            PC         <= '0;
            InstrCount <= '0;
            tmo_cnt    <= '0;
            wrapped    <= 1'b0;
        end else begin
            Run <= 1'b0;
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (Start) begin
                        state      <= S_ISSUE;
                        PC         <= '0;
                        InstrCount <= '0;
                        Halted     <= 1'b0;
                        Error      <= 1'b0;
                        tmo_cnt    <= '0;
                    end
                end
                S_ISSUE: begin
                    PC      <= PC + 1'b1;
                    wrapped <= pc_last;
                    tmo_cnt <= '0;
                    if (word[8:6] == OP_HALT) begin
                        state  <= S_HALT;
                        Halted <= 1'b1;
                    end else begin
                        Run   <= 1'b1;
                        DIN   <= word;
                        state <= (word[8:6] == OP_MVI) ? S_IMM : S_WAIT;
                    end
                end
                S_IMM: begin
                    DIN     <= word;
                    PC      <= PC + 1'b1;
                    wrapped <= wrapped | pc_last;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (Done) begin
                        if (InstrCount != 8'hFF) begin
                            InstrCount <= InstrCount + 1'b1;
                        end
                        tmo_cnt <= '0;
                        if (wrapped) begin
                            state  <= S_HALT;
                            Halted <= 1'b1;
                        end else begin
`ifdef PROC_FEEDER_STEP_EN
                            state <= S_PAUSE;
`else
                            state <= S_ISSUE;
`endif
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state <= S_ERR;
                        Error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`ifdef PROC_FEEDER_STEP_EN
                S_PAUSE: begin
                    if (Step) begin
                        state <= S_ISSUE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_feeder.sv
// Directed bench for proc_feeder: a scoreboard queue holds the words each Run pulse must carry.
module tb_proc_feeder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Step  = 1'b0;
    logic       LoadEn = 1'b0;
    logic [4:0] LoadAddr = '0;
    logic [8:0] LoadData = '0;
    logic       Done = 1'b0;
    logic [8:0] DIN;
    logic       Run;
    logic       Busy;
    logic       Halted;
    logic       Error;
    logic [4:0] PC;
    logic [7:0] InstrCount;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [8:0] word;
        bit         has_imm;
        logic [8:0] imm;
    } exp_t;

    exp_t       exp_q[$];
    bit         pend_imm = 1'b0;
    logic [8:0] pend_val = '0;
    bit         prev_run = 1'b0;

    proc_feeder dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
`ifdef PROC_FEEDER_STEP_EN
        .Step       (Step),
`endif
        .LoadEn     (LoadEn),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData),
        .Done       (Done),
        .DIN        (DIN),
        .Run        (Run),
        .Busy       (Busy),
        .Halted     (Halted),
        .Error      (Error),
        .PC         (PC),
        .InstrCount (InstrCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input logic [8:0] w, input bit h, input logic [8:0] i);
        exp_t e;
        e.word = w;
        e.has_imm = h;
        e.imm = i;
        exp_q.push_back(e);
    endfunction

    // Run-pulse monitor: pops the scoreboard on every Run and checks the following immediate.
    always @(negedge Clock) begin
        exp_t e;
        if (pend_imm) begin
            check("imm_din", 32'(DIN), 32'(pend_val));
            pend_imm = 1'b0;
        end
        if (Run) begin
            check("run_not_back_to_back", 32'(prev_run), 32'd0);
            check("run_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("run_din", 32'(DIN), 32'(e.word));
                if (e.has_imm) begin
                    pend_imm = 1'b1;
                    pend_val = e.imm;
                end
            end
        end
        prev_run = Run;
    end

    task automatic load(input logic [4:0] a, input logic [8:0] d);
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!Run && n < 40);
        check("run_seen", 32'(Run), 32'd1);
    endtask

    task automatic give_done(input int d);
        repeat (d) @(negedge Clock);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!Halted && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check("halted_seen", 32'(Halted), 32'd1);
    endtask

    initial begin
        int n;
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clock);
        check("rst_din", 32'(DIN), 32'd0);
        check("rst_run", 32'(Run), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_count", 32'(InstrCount), 32'd0);
        Reset = 1'b0;

        // mvi R0, #5 then halt
        load(5'd0, 9'h040);
        load(5'd1, 9'h005);
        load(5'd2, 9'h1C0);
        push_exp(9'h040, 1'b1, 9'h005);
        pulse_start();
        check("t1_busy", 32'(Busy), 32'd1);
        wait_run();
        give_done(1);
        wait_halt();
        check("t1_count", 32'(InstrCount), 32'd1);
        check("t1_pc", 32'(PC), 32'd3);
        check("t1_busy_done", 32'(Busy), 32'd0);

        // add with Done three cycles after Run; DIN must hold
        load(5'd0, 9'h08A);
        load(5'd1, 9'h1C0);
        push_exp(9'h08A, 1'b0, 9'h000);
        pulse_start();
        wait_run();
        repeat (2) begin
            @(negedge Clock);
            check("t2_din_hold", 32'(DIN), 32'h08A);
            check("t2_busy", 32'(Busy), 32'd1);
        end
        give_done(1);
        wait_halt();
        check("t2_count", 32'(InstrCount), 32'd1);
        check("t2_din_after", 32'(DIN), 32'h08A);

        // Done never arrives -> Error exactly 15 cycles after entering WAIT
        load(5'd0, 9'h001);
        push_exp(9'h001, 1'b0, 9'h000);
        pulse_start();
        wait_run();
        n = 0;
        while (!Error && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check("t3_timeout_cycles", 32'(n), 32'd15);
        check("t3_error", 32'(Error), 32'd1);
        check("t3_busy", 32'(Busy), 32'd0);
        push_exp(9'h001, 1'b0, 9'h000);
        pulse_start();
        check("t3_error_cleared", 32'(Error), 32'd0);
        wait_run();
        check("t3_pc_reissue", 32'(PC), 32'd1);
        give_done(1);
        wait_halt();
        check("t3_count", 32'(InstrCount), 32'd1);

        // 32 mv instructions -> PC wraps and halts
        for (int a = 0; a < 32; a++) begin
            load(5'(a), 9'h001);
            push_exp(9'h001, 1'b0, 9'h000);
        end
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            wait_run();
            give_done(1);
        end
        wait_halt();
        check("t4_pc_wrap", 32'(PC), 32'd0);
        check("t4_count", 32'(InstrCount), 32'd32);

        // Load and Start while Busy are dropped
        load(5'd0, 9'h0C5);
        load(5'd1, 9'h1C0);
        push_exp(9'h0C5, 1'b0, 9'h000);
        pulse_start();
        wait_run();
        load(5'd0, 9'h1C0);
        pulse_start();
        check("t5_pc_busy", 32'(PC), 32'd1);
        check("t5_busy", 32'(Busy), 32'd1);
        give_done(1);
        wait_halt();
        check("t5_count", 32'(InstrCount), 32'd1);
        push_exp(9'h0C5, 1'b0, 9'h000);
        pulse_start();
        wait_run();
        give_done(1);
        wait_halt();

        // Simultaneous load and Start from HALT: write-first
        push_exp(9'h08A, 1'b0, 9'h000);
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = 5'd0; LoadData = 9'h08A; Start = 1'b1;
        @(negedge Clock);
        LoadEn = 1'b0; Start = 1'b0;
        wait_run();
        give_done(1);
        wait_halt();
        check("t5_wf_count", 32'(InstrCount), 32'd1);

`ifdef PROC_FEEDER_STEP_EN
        load(5'd0, 9'h001);
        load(5'd1, 9'h001);
        load(5'd2, 9'h1C0);
        push_exp(9'h001, 1'b0, 9'h000);
        push_exp(9'h001, 1'b0, 9'h000);
        pulse_start();
        wait_run();
        give_done(1);
        repeat (20) @(negedge Clock);
        check("t6_pause_error", 32'(Error), 32'd0);
        check("t6_pause_busy", 32'(Busy), 32'd1);
        check("t6_pause_count", 32'(InstrCount), 32'd1);
        @(negedge Clock);
        Step = 1'b1;
        @(negedge Clock);
        Step = 1'b0;
        wait_run();
        give_done(1);
        @(negedge Clock);
        Step = 1'b1;
        @(negedge Clock);
        Step = 1'b0;
        wait_halt();
        check("t6_count", 32'(InstrCount), 32'd2);
`endif

        repeat (3) @(negedge Clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
